// File: rtl/cic_pkg.sv
// CIC decimator shared constants and derivation helpers.
// Output width, filter order, legal ratios and width/shift math.
package cic_pkg;

    localparam int CIC_ORDER = 3;
    localparam int OUT_W     = 16;

    localparam int DECIM_32  = 32;
    localparam int DECIM_64  = 64;
    localparam int DECIM_128 = 128;

    function automatic int log2_decim(input int d);
        int r;
        r = 0;
        for (int k = 0; k < 16; k++) begin
            if ((1 << k) == d) begin
                r = k;
            end
        end
        return r;
    endfunction

    function automatic bit decim_legal(input int d);
        return (d == DECIM_32) || (d == DECIM_64) || (d == DECIM_128);
    endfunction

    // Bit growth is ORDER*log2(R) on a 2-bit signed +/-1 input.
    function automatic int acc_width(input int d);
        return CIC_ORDER * log2_decim(d) + 2;
    endfunction

    // Right shift that maps DC gain R^3 onto 2^(OUT_W-1).
    function automatic int out_shift(input int d);
        return CIC_ORDER * log2_decim(d) - (OUT_W - 1);
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb section, differential delay 1.
// Delay register advances only on the decimation tick.
module cic_comb_stage #(
    parameter int ACC_W = 20
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    en,
    input  logic signed [ACC_W-1:0] din,
    output logic signed [ACC_W-1:0] dout
);

    logic signed [ACC_W-1:0] dly;

    assign dout = din - dly;

    // Capture the current input as next frame's delayed sample.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            dly <= '0;
        end else if (en) begin
            dly <= din;
        end
    end

endmodule

// File: rtl/cic_decimator.sv
// 3rd-order CIC decimator for a 1-bit sigma-delta stream.
// Define CIC_OUT_SAT_EN to clamp the scaled output instead of wrapping.
module cic_decimator
    import cic_pkg::*;
#(
    parameter int DECIM = 64,
    parameter int ACC_W = acc_width(DECIM)
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    BIT_IN,
    input  logic                    BIT_VALID,
    output logic signed [OUT_W-1:0] OUTPUT_DATA,
    output logic                    OUT_VALID
);

    localparam int PH_W  = log2_decim(DECIM);
    localparam int SHIFT = out_shift(DECIM);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);

    logic signed [ACC_W-1:0] bit_val;
    logic signed [ACC_W-1:0] i1, i2, i3;
    logic signed [ACC_W-1:0] i1_nxt, i2_nxt, i3_nxt;
    logic signed [ACC_W-1:0] c1, c2, c3;
    logic signed [ACC_W-1:0] scaled;
    logic signed [OUT_W-1:0] sample;
    logic [PH_W-1:0]         phase;
    logic                    tick;

    // 1 -> +1, 0 -> -1, sign-extended to the accumulator width.
    assign bit_val = {{(ACC_W-1){~BIT_IN}}, 1'b1};

    // Integrators chain combinationally so i3 already holds the current bit.
    assign i1_nxt = i1 + bit_val;
    assign i2_nxt = i2 + i1_nxt;
    assign i3_nxt = i3 + i2_nxt;

    // Integrators advance on accepted bits only, wrapping freely.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            i1 <= '0;
            i2 <= '0;
            i3 <= '0;
        end else if (BIT_VALID) begin
            i1 <= i1_nxt;
            i2 <= i2_nxt;
            i3 <= i3_nxt;
        end
    end

    // Phase counter and tick raised on the edge taking the last bit of a frame.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            phase <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= BIT_VALID && (phase == PH_LAST);
            if (BIT_VALID) begin
                phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
            end
        end
    end

    cic_comb_stage #(.ACC_W(ACC_W)) u_comb1 (
        .CLK  (CLK),
        .RST_N(RST_N),
        .en   (tick),
        .din  (i3),
        .dout (c1)
    );

    cic_comb_stage #(.ACC_W(ACC_W)) u_comb2 (
        .CLK  (CLK),
        .RST_N(RST_N),
        .en   (tick),
        .din  (c1),
        .dout (c2)
    );

    cic_comb_stage #(.ACC_W(ACC_W)) u_comb3 (
        .CLK  (CLK),
        .RST_N(RST_N),
        .en   (tick),
        .din  (c2),
        .dout (c3)
    );

    assign scaled = c3 >>> SHIFT;

`ifdef CIC_OUT_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-32768);

    // Clamp the scaled comb result into the Q1.15 range.
    always_comb begin
        sample = OUT_W'(scaled);
        if (scaled > SAT_HI) begin
            sample = 16'sh7fff;
        end else if (scaled < SAT_LO) begin
            sample = 16'sh8000;
        end
    end
`else
    assign sample = OUT_W'(scaled);
`endif

    // Load a new sample and strobe for one cycle on the tick.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            OUTPUT_DATA <= '0;
            OUT_VALID   <= 1'b0;
        end else begin
            OUT_VALID <= tick;
            if (tick) begin
                OUTPUT_DATA <= sample;
            end
        end
    end

endmodule

// File: tb/tb_cic_decimator.sv
// Self-checking bench for cic_decimator at DECIM 32, 64 and 128.
// Reference: direct convolution with the CIC impulse response.
module tb_cic_decimator;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    logic BIT_IN = 1'b0;
    logic BIT_VALID = 1'b0;

    logic signed [15:0] od32, od64, od128;
    logic ov32, ov64, ov128;

    cic_decimator #(.DECIM(32)) dut32 (
        .CLK(CLK), .RST_N(RST_N), .BIT_IN(BIT_IN), .BIT_VALID(BIT_VALID),
        .OUTPUT_DATA(od32), .OUT_VALID(ov32)
    );
    cic_decimator #(.DECIM(64)) dut64 (
        .CLK(CLK), .RST_N(RST_N), .BIT_IN(BIT_IN), .BIT_VALID(BIT_VALID),
        .OUTPUT_DATA(od64), .OUT_VALID(ov64)
    );
    cic_decimator #(.DECIM(128)) dut128 (
        .CLK(CLK), .RST_N(RST_N), .BIT_IN(BIT_IN), .BIT_VALID(BIT_VALID),
        .OUTPUT_DATA(od128), .OUT_VALID(ov128)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int passes = 0;

    int dec[3] = '{32, 64, 128};
    int lg[3]  = '{5, 6, 7};
    int htab[3][0:381];

`ifdef CIC_OUT_SAT_EN
    localparam logic signed [15:0] FULL_POS = 16'sh7fff;
`else
    localparam logic signed [15:0] FULL_POS = 16'sh8000;
`endif

    bit stream[$];
    logic signed [15:0] seq64[$];
    logic signed [15:0] ref75[$];
    int cnt[3];
    bit pend[3];
    int nstr[3];
    int first_acc[3];
    logic signed [15:0] last_od[3];
    int acc_since_rst = 0;

    logic mon_acc, mon_bit;
    logic mon_ov[3];
    logic signed [15:0] mon_od[3];
    logic signed [15:0] mon_exp;

    // Impulse response of three cascaded length-D boxcars.
    task automatic build_h();
        int d, s, t;
        for (int di = 0; di < 3; di++) begin
            d = dec[di];
            for (int j = 0; j < 382; j++) begin
                s = 0;
                for (int a = 0; a < d; a++) begin
                    t = j - a;
                    if (t >= 0 && t <= 2 * d - 2)
                        s += (t < d) ? t + 1 : 2 * d - 1 - t;
                end
                htab[di][j] = (j <= 3 * d - 3) ? s : 0;
            end
        end
    endtask

    // Output n (1-based) after reset: convolution over the first n*D bits.
    function automatic logic signed [15:0] model(int di, int n);
        int d, m, lo, hi, aw, sh;
        longint y, md;
        d = dec[di];
        m = n * d;
        lo = m - 3 * d + 2;
        if (lo < 0) lo = 0;
        hi = (m < stream.size()) ? m : stream.size();
        y = 0;
        for (int k = lo; k < hi; k++)
            y += stream[k] ? htab[di][m-1-k] : -htab[di][m-1-k];
        aw = 3 * lg[di] + 2;
        sh = 3 * lg[di] - 15;
        md = 64'sd1 <<< aw;
        y = y % md;
        if (y < 0) y += md;
        if (y >= md / 2) y -= md;
        y = y >>> sh;
`ifdef CIC_OUT_SAT_EN
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
`endif
        return 16'(y);
    endfunction

    // Per-edge monitor: strobe timing, sample values, hold, reset state.
    always @(posedge CLK) begin
        mon_acc = RST_N && BIT_VALID;
        mon_bit = BIT_IN;
        #1;
        mon_ov[0] = ov32;  mon_od[0] = od32;
        mon_ov[1] = ov64;  mon_od[1] = od64;
        mon_ov[2] = ov128; mon_od[2] = od128;
        for (int i = 0; i < 3; i++) begin
            if (!RST_N) begin
                checks++;
                if (mon_ov[i] !== 1'b0 || mon_od[i] !== 16'sd0)
                    $display("FAIL reset_state dut%0d: valid=%b data=%0d want 0/0",
                             dec[i], mon_ov[i], mon_od[i]);
                else passes++;
                cnt[i] = 0; pend[i] = 0; nstr[i] = 0;
                first_acc[i] = -1; last_od[i] = 0;
            end else begin
                checks++;
                if (mon_ov[i] !== pend[i])
                    $display("FAIL strobe_timing dut%0d: valid=%b want %b at bit %0d",
                             dec[i], mon_ov[i], pend[i], cnt[i]);
                else passes++;
                if (mon_ov[i] === 1'b1) begin
                    nstr[i]++;
                    mon_exp = model(i, nstr[i]);
                    checks++;
                    if (mon_od[i] !== mon_exp)
                        $display("FAIL sample dut%0d #%0d: got %0d want %0d",
                                 dec[i], nstr[i], mon_od[i], mon_exp);
                    else passes++;
                    last_od[i] = mon_od[i];
                    if (first_acc[i] < 0) first_acc[i] = cnt[i];
                    if (i == 1) seq64.push_back(mon_od[i]);
                end else begin
                    checks++;
                    if (mon_od[i] !== last_od[i])
                        $display("FAIL hold dut%0d: got %0d want %0d",
                                 dec[i], mon_od[i], last_od[i]);
                    else passes++;
                end
                pend[i] = 0;
                if (mon_acc) begin
                    cnt[i]++;
                    pend[i] = (cnt[i] % dec[i] == 0);
                end
            end
        end
        if (!RST_N) begin
            stream.delete();
            seq64.delete();
        end else if (mon_acc) begin
            stream.push_back(mon_bit);
        end
    end

    function automatic logic patbit(int mode, int idx);
        case (mode)
            0: return 1'b1;
            1: return 1'b0;
            2: return (idx % 2 == 0);
            3: return (idx % 4 != 3);
            default: return 1'($urandom_range(1));
        endcase
    endfunction

    // Drive until n bits accepted; caller sits at a negedge.
    task automatic feed(int n, int mode, int pct);
        int got, cyc;
        logic v;
        got = 0;
        cyc = 0;
        while (got < n && cyc < n * 20 + 200) begin
            v = ($urandom_range(99) < pct);
            BIT_VALID = v;
            BIT_IN = v ? patbit(mode, acc_since_rst) : 1'($urandom_range(1));
            if (v) begin
                got++;
                acc_since_rst++;
            end
            @(negedge CLK);
            cyc++;
        end
        BIT_VALID = 1'b0;
        checks++;
        if (got != n)
            $display("FAIL feed_budget: accepted %0d want %0d", got, n);
        else passes++;
    endtask

    task automatic idle(int k);
        BIT_VALID = 1'b0;
        repeat (k) @(negedge CLK);
    endtask

    // Async assert with immediate clear check, then release at a negedge.
    task automatic do_reset();
        RST_N = 1'b0;
        BIT_VALID = 1'b0;
        #1;
        checks++;
        if ({ov32, ov64, ov128} !== 3'b000 || od32 !== 0 || od64 !== 0 || od128 !== 0)
            $display("FAIL async_reset: valid=%b%b%b data=%0d/%0d/%0d want zeros",
                     ov32, ov64, ov128, od32, od64, od128);
        else passes++;
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        acc_since_rst = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLK);
        checks++;
        if ({ov32, ov64, ov128} !== 3'b000 || od64 !== 16'sd0)
            $display("FAIL test_reset: valid=%b%b%b data=%0d want zeros",
                     ov32, ov64, ov128, od64);
        else passes++;
        RST_N = 1'b1;
        idle(2);
    endtask

    task automatic test_ones();
        do_reset();
        feed(640, 0, 100);
        idle(3);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (last_od[i] !== FULL_POS)
                $display("FAIL ones dut%0d: got %0d want %0d", dec[i], last_od[i], FULL_POS);
            else passes++;
            checks++;
            if (nstr[i] != 640 / dec[i])
                $display("FAIL ones_count dut%0d: got %0d want %0d", dec[i], nstr[i], 640 / dec[i]);
            else passes++;
        end
    endtask

    task automatic test_zeros();
        do_reset();
        feed(640, 1, 100);
        idle(3);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (last_od[i] !== -16'sd32768)
                $display("FAIL zeros dut%0d: got %0d want -32768", dec[i], last_od[i]);
            else passes++;
        end
    endtask

    task automatic test_alternating();
        do_reset();
        feed(640, 2, 100);
        idle(3);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (last_od[i] !== 16'sd0)
                $display("FAIL alternating dut%0d: got %0d want 0", dec[i], last_od[i]);
            else passes++;
        end
    endtask

    task automatic test_ratio75();
        do_reset();
        feed(640, 3, 100);
        idle(3);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (last_od[i] !== 16'sd16384)
                $display("FAIL ratio75 dut%0d: got %0d want 16384", dec[i], last_od[i]);
            else passes++;
        end
        ref75 = seq64;
    endtask

    task automatic test_gappy();
        do_reset();
        feed(640, 3, 30);
        idle(3);
        checks++;
        if (last_od[1] !== 16'sd16384)
            $display("FAIL gappy_value: got %0d want 16384", last_od[1]);
        else passes++;
        checks++;
        if (seq64.size() != ref75.size() || ref75.size() != 10)
            $display("FAIL gappy_len: got %0d want %0d (ref %0d)", seq64.size(), 10, ref75.size());
        else passes++;
        for (int k = 0; k < ref75.size() && k < seq64.size(); k++) begin
            checks++;
            if (seq64[k] !== ref75[k])
                $display("FAIL gappy_seq[%0d]: got %0d want %0d", k, seq64[k], ref75[k]);
            else passes++;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        feed(40, 0, 100);
        do_reset();
        feed(64, 0, 100);
        idle(3);
        checks++;
        if (first_acc[1] != 64 || nstr[1] != 1)
            $display("FAIL reset_mid_first: at bit %0d count %0d want 64/1", first_acc[1], nstr[1]);
        else passes++;
        checks++;
        if (first_acc[0] != 32 || nstr[0] != 2)
            $display("FAIL reset_mid_d32: at bit %0d count %0d want 32/2", first_acc[0], nstr[0]);
        else passes++;
        checks++;
        if (last_od[1] !== 16'sd5720)
            $display("FAIL reset_mid_warmup: got %0d want 5720", last_od[1]);
        else passes++;
    endtask

    task automatic test_random();
        do_reset();
        feed(1024, 4, 50);
        idle(3);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (nstr[i] != 1024 / dec[i])
                $display("FAIL random_count dut%0d: got %0d want %0d", dec[i], nstr[i], 1024 / dec[i]);
            else passes++;
        end
    endtask

    initial begin
        build_h();
        test_reset();
        test_ones();
        test_zeros();
        test_alternating();
        test_ratio75();
        test_gappy();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
